spi_gate_ctrl: RTL and testbench
================================

// Module: spi_gate_ctrl
// PURPOSE
// - Sequencer directly upstream of clock_gate: drives its enable so exactly N SCLK pulses
//   (gated clk_in) reach the SPI bus per transfer.
// - Frames each burst with chip-select setup (LEAD) and hold (LAG) intervals.
// - Provides a valid/ready start handshake, abort, and done/bit-index status to the SPI master.
// PARAMETERS
// - MAX_BITS  32                      Largest legal burst length in SCLK pulses.
// - CNT_W     $clog2(MAX_BITS+1)      Width of num_bits and the internal bit counter.
// - LEAD      2                       clk_in cycles cs_n is low before the first pulse (0 legal).
// - LAG       2                       clk_in cycles cs_n stays low after the last pulse (0 legal).
// PORTS
// - clk_in       in   1      Free-running clock; same net fed to clock_gate.clk_in.
// - rst_n        in   1      Reset: asynchronous assert, active-low.
// - start_valid  in   1      Request a transfer.
// - start_ready  out  1      High only in IDLE; start_valid & start_ready at a rising edge = accept.
// - num_bits     in   CNT_W  Burst length, sampled at accept.
// - abort        in   1      Terminate the current transfer early.
// - gate_en      out  1      To clock_gate.enable. Registered, changes only on the clk_in rising edge.
// - cs_n         out  1      Chip select, active-low.
// - busy         out  1      High in any state other than IDLE.
// - bit_idx      out  CNT_W  Index of the pulse currently enabled; valid while gate_en=1.
// - done         out  1      One-cycle pulse when the transfer completes.
// - aborted      out  1      Qualifies done: 1 means the transfer ended by abort.
// BEHAVIOUR
// - Reset: state IDLE, gate_en=0, cs_n=1, busy=0, done=0, aborted=0, bit_idx=0, start_ready=1.
//   Reset takes effect immediately, including mid-transfer; the gate closes with no runt pulse
//   because clock_gate latches enable low.
// - FSM: IDLE -> LEAD -> SHIFT -> LAG -> IDLE. LEAD=0 skips LEAD; LAG=0 skips LAG.
// - Accept at edge E0:
//   - num_bits is latched. 0 means an empty burst: SHIFT is skipped.
//     Values above MAX_BITS are clamped to MAX_BITS.
//   - After E0: cs_n=0 and busy=1.
//   - If LEAD>0: state=LEAD and gate_en=0. Otherwise state=SHIFT and gate_en=1.
// - LEAD: remains for exactly LEAD cycles, then gate_en=1 and state=SHIFT.
// - SHIFT: gate_en=1 for exactly N consecutive cycles.
//   - bit_idx runs 0..N-1, incrementing once per cycle.
//   - gate_en drops on the edge that ends cycle N.
// - LAG: gate_en=0 and cs_n=0 for exactly LAG cycles.
// - Exit to IDLE: cs_n=1, busy=0, done=1 for that single cycle.
//   - Total cs_n low time is LEAD+N+LAG cycles.
//   - A start accepted in the done cycle is legal. cs_n is then high for exactly 1 cycle
//     between bursts, which is the minimum.
// - abort in LEAD or SHIFT:
//   - On the next edge gate_en=0 and state=LAG; no partial pulse follows.
//   - LAG runs in full, then done=1 with aborted=1.
// - abort in LAG: ignored; LAG completes normally and aborted reflects any earlier abort.
// - abort in IDLE: ignored.
// - abort and start_valid together in IDLE: start is accepted and abort is ignored.
// - aborted holds its value until the next accept, which clears it.
// - Counters never wrap: the phase counter and bit counter load at phase entry and stop at terminal.
// STRUCTURE
// - spi_pkg holds:
//   - typedef enum logic [1:0] {IDLE, LEAD, SHIFT, LAG} gate_state_t
//   - localparams for default LEAD and LAG.
// - One sub-module, phase_counter: loadable down-counter with load, en and zero outputs.
//   It is shared for the LEAD, SHIFT and LAG phase lengths. bit_idx comes from a separate up-count.
// - All outputs are registered. No logic on clk_in other than the flop clocks.
// TESTING
// 1. Reset, then start with num_bits=8, LEAD=2, LAG=2:
//    cs_n low 12 cycles, gate_en high cycles 3-10, 8 clk_out pulses, done 1 cycle, aborted=0.
// 2. Assert start_valid in the done cycle with num_bits=4:
//    cs_n high exactly 1 cycle, then second burst of 4 pulses, bit_idx 0..3.
// 3. num_bits=0: no gate_en, cs_n low LEAD+LAG=4 cycles, done pulses.
//    num_bits=40: exactly 32 pulses.
// 4. abort on SHIFT pulse 3 of 8: gate_en low next edge, 3 or 4 pulses total, LAG 2 cycles,
//    done=1 with aborted=1.
// 5. rst_n low mid-SHIFT, asynchronous and between edges:
//    gate_en=0, cs_n=1, busy=0 immediately, no glitch on clk_out.
// 6. Parameter sweep LEAD=0, LAG=0, num_bits=1:
//    cs_n low 1 cycle, gate_en and cs_n coincident, one pulse, done on the following cycle.

Source files
------------

// File: rtl/spi_gate_ctrl_pkg.sv
// Shared types and defaults for the SPI clock-gate sequencer.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, LAG} gate_state_t;

  localparam int LEAD_DEFAULT = 2;
  localparam int LAG_DEFAULT  = 2;

  // Phase that follows 'from', skipping any phase whose length is zero.
  // An abort out of LEAD or SHIFT is requested by passing SHIFT as 'from'.
  function automatic gate_state_t next_phase(input gate_state_t from,
                                             input logic has_lead,
                                             input logic has_bits,
                                             input logic has_lag);
    gate_state_t nxt;
    nxt = IDLE;
    case (from)
      IDLE:  nxt = has_lead ? LEAD : (has_bits ? SHIFT : (has_lag ? LAG : IDLE));
      LEAD:  nxt = has_bits ? SHIFT : (has_lag ? LAG : IDLE);
      SHIFT: nxt = has_lag ? LAG : IDLE;
      LAG:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/spi_gate_ctrl_phase_counter.sv
// Loadable down-counter timing the LEAD, SHIFT and LAG phases.
// Holds at zero; a load always wins over a decrement.
module phase_counter #(
  parameter int W = 6
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load at phase entry, otherwise count down to terminal and stop there.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/spi_gate_ctrl.sv
// Sequencer driving clock_gate.enable so that exactly N SCLK pulses reach
// the bus per transfer, framed by chip-select setup and hold intervals.
//
// state | meaning
// IDLE  | cs_n high, ready for a start request
// LEAD  | cs_n low, gate closed, chip-select setup time
// SHIFT | gate open, one SCLK pulse per cycle, bit_idx counts up
// LAG   | cs_n low, gate closed, chip-select hold time
module spi_gate_ctrl
  import spi_pkg::*;
#(
  parameter int MAX_BITS = 32,
  parameter int CNT_W    = $clog2(MAX_BITS + 1),
  parameter int LEAD     = LEAD_DEFAULT,
  parameter int LAG      = LAG_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] num_bits,
  input  logic             abort,
  output logic             gate_en,
  output logic             cs_n,
  output logic             busy,
  output logic [CNT_W-1:0] bit_idx,
  output logic             done,
  output logic             aborted
);

  // The phase counter must hold the longest of the three phase lengths.
  localparam int PH_MAX = (MAX_BITS > LEAD) ? ((MAX_BITS > LAG) ? MAX_BITS : LAG)
                                            : ((LEAD > LAG) ? LEAD : LAG);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] LEAD_LD = (LEAD > 0) ? PH_W'(LEAD - 1) : '0;
  localparam logic [PH_W-1:0] LAG_LD  = (LAG > 0)  ? PH_W'(LAG - 1)  : '0;

  gate_state_t     state;
  gate_state_t     target;
  gate_state_t     from_state;
  logic            advance;
  logic            abort_hit;
  logic            has_bits;
  logic [CNT_W-1:0] n_req;
  logic [CNT_W-1:0] n_bits;
  logic [CNT_W-1:0] n_use;
  logic [PH_W-1:0] load_val;
  logic            ph_zero;

  assign n_req = (num_bits > CNT_W'(MAX_BITS)) ? CNT_W'(MAX_BITS) : num_bits;

  // Decide whether the current phase ends this cycle and which phase follows.
  // In IDLE the burst length comes straight from the request being accepted.
  always_comb begin
    n_use      = (state == IDLE) ? n_req : n_bits;
    has_bits   = (n_use != '0);
    advance    = 1'b0;
    abort_hit  = 1'b0;
    unique case (state)
      IDLE:             advance = start_valid;
      spi_pkg::LEAD,
      SHIFT: begin
        advance   = ph_zero | abort;
        abort_hit = abort;
      end
      spi_pkg::LAG:     advance = ph_zero;
    endcase
    from_state = abort_hit ? SHIFT : state;
    target     = next_phase(from_state, (LEAD > 0), has_bits, (LAG > 0));
    load_val   = '0;
    unique case (target)
      spi_pkg::LEAD: load_val = LEAD_LD;
      SHIFT:         load_val = PH_W'(n_use) - PH_W'(1);
      spi_pkg::LAG:  load_val = LAG_LD;
      IDLE:          load_val = '0;
    endcase
  end

  phase_counter #(.W(PH_W)) u_phase (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .load     (advance),
    .en       (state != IDLE),
    .load_val (load_val),
    .zero     (ph_zero)
  );

  // Sequencer state and registered outputs, all updated on phase entry.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gate_en     <= 1'b0;
      cs_n        <= 1'b1;
      busy        <= 1'b0;
      start_ready <= 1'b1;
      done        <= 1'b0;
      aborted     <= 1'b0;
      bit_idx     <= '0;
      n_bits      <= '0;
    end else begin
      done <= 1'b0;
      if ((state == SHIFT) && !advance) begin
        bit_idx <= bit_idx + CNT_W'(1);
      end
      if (advance) begin
        state       <= target;
        gate_en     <= (target == SHIFT);
        cs_n        <= (target == IDLE);
        busy        <= (target != IDLE);
        start_ready <= (target == IDLE);
        done        <= (target == IDLE);
        if (target == SHIFT) begin
          bit_idx <= '0;
        end
        if (state == IDLE) begin
          n_bits  <= n_req;
          aborted <= 1'b0;
        end else if (abort_hit) begin
          aborted <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_gate_ctrl.sv
// Bench for spi_gate_ctrl: one instance with LEAD=LAG=2 and one with
// LEAD=LAG=0, checked cycle by cycle against a phase-length reference model.
module tb_spi_gate_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic [1:0] sv;
  logic [5:0] num_bits;
  logic       abort;
  logic [1:0] sr, ge, csn, bsy, dn, ab;
  logic [5:0] bi0, bi1;
  logic [1:0] en_lat = '0;
  int         sel = 0;
  int         pulse_cnt = 0;
  int         tests = 0;
  int         fails = 0;
  logic [10:0] obs_q [0:63];
  int         cur_len;
  int         got_pulses;

  always #5 clk_in = ~clk_in;

  spi_gate_ctrl dut (
    .clk_in(clk_in), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr[0]),
    .num_bits(num_bits), .abort(abort), .gate_en(ge[0]), .cs_n(csn[0]),
    .busy(bsy[0]), .bit_idx(bi0), .done(dn[0]), .aborted(ab[0]));

  spi_gate_ctrl #(.LEAD(0), .LAG(0)) dut0 (
    .clk_in(clk_in), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr[1]),
    .num_bits(num_bits), .abort(abort), .gate_en(ge[1]), .cs_n(csn[1]),
    .busy(bsy[1]), .bit_idx(bi1), .done(dn[1]), .aborted(ab[1]));

  // Clock-gate model: enable latched while clk_in is low, pulses counted on clk_out.
  always @(negedge clk_in) en_lat <= ge;
  always @(posedge clk_in) if (en_lat[sel] === 1'b1) pulse_cnt++;

  function automatic logic [10:0] obs_vec(input int s);
    logic [5:0] b;
    b = (s == 0) ? bi0 : bi1;
    return {csn[s], ge[s], bsy[s], dn[s], ab[s], (ge[s] ? b : 6'd0)};
  endfunction

  // Reference: timeline of one transfer from its phase lengths.
  // k counts cycles after the accepting edge; abk is the cycle abort is held (0 = none).
  function automatic logic [10:0] model(input int s, input int n, input int abk, input int k,
                                        output int len, output int pulses);
    int lead, lag, nc, lead_e, n_e, tot, bidx;
    logic cs, g, by, d, a;
    lead = (s == 0) ? 2 : 0;
    lag  = lead;
    nc   = (n > 32) ? 32 : n;
    lead_e = lead; n_e = nc; a = 1'b0;
    if (abk >= 1 && abk <= lead) begin
      lead_e = abk; n_e = 0; a = 1'b1;
    end else if (abk > lead && abk <= lead + nc) begin
      n_e = abk - lead; a = 1'b1;
    end
    tot = lead_e + n_e + lag;
    len = tot + 1;
    pulses = n_e;
    cs = 1'b1; g = 1'b0; by = 1'b0; d = 1'b0; bidx = 0;
    if (k <= tot) begin
      cs = 1'b0; by = 1'b1;
      if (k > lead_e && k <= lead_e + n_e) begin
        g = 1'b1; bidx = k - lead_e - 1;
      end
    end else begin
      d = (k == tot + 1);
    end
    a = a && (k > abk);
    return {cs, g, by, d, a, 6'(bidx)};
  endfunction

  task automatic begin_start(input int s, input int n, input logic with_abort);
    @(negedge clk_in);
    sel = s; sv[s] = 1'b1; num_bits = 6'(n); abort = with_abort;
    @(posedge clk_in); #1;
    sv = '0; abort = 1'b0; pulse_cnt = 0;
  endtask

  // Captures one transfer; optionally raises a chained start in its done cycle.
  task automatic capture(input int s, input int n, input int abk, input int nxt_n);
    int len, pul;
    logic [10:0] e;
    e = model(s, n, abk, 1, len, pul);
    cur_len = len;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk_in);
      obs_q[k] = obs_vec(s);
      abort = (k == abk);
      if (k == len && nxt_n >= 0) begin
        sv[s] = 1'b1; num_bits = 6'(nxt_n);
      end
    end
    got_pulses = pulse_cnt;
    @(posedge clk_in); #1;
    sv = '0; abort = 1'b0; pulse_cnt = 0;
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    for (int s = 0; s < 2; s++) begin
      tests++;
      if ({obs_vec(s), sr[s]} !== {11'b1_0_0_0_0_000000, 1'b1}) begin
        fails++;
        $display("FAIL reset s=%0d got=%b required=%b", s, {obs_vec(s), sr[s]}, 12'b100000000001);
      end
    end
    tests++;
    if ({bi0, bi1} !== 12'd0) begin
      fails++;
      $display("FAIL reset_bit_idx got=%0d,%0d required=0,0", bi0, bi1);
    end
  endtask

  task automatic test_basic();
    int len, pul;
    logic [10:0] e;
    begin_start(0, 8, 1'b0);
    capture(0, 8, 0, -1);
    for (int k = 1; k <= cur_len; k++) begin
      e = model(0, 8, 0, k, len, pul);
      tests++;
      if (obs_q[k] !== e) begin
        fails++; $display("FAIL basic k=%0d got=%b required=%b", k, obs_q[k], e);
      end
    end
    tests++;
    if (got_pulses !== 8 || cur_len !== 13) begin
      fails++; $display("FAIL basic_pulses got=%0d/%0d required=8/13", got_pulses, cur_len);
    end
  endtask

  task automatic test_back_to_back();
    int len, pul;
    logic [10:0] e;
    begin_start(0, 5, 1'b0);
    capture(0, 5, 0, 4);
    for (int k = 1; k <= cur_len; k++) begin
      e = model(0, 5, 0, k, len, pul);
      tests++;
      if (obs_q[k] !== e) begin
        fails++; $display("FAIL b2b_first k=%0d got=%b required=%b", k, obs_q[k], e);
      end
    end
    capture(0, 4, 0, -1);
    for (int k = 1; k <= cur_len; k++) begin
      e = model(0, 4, 0, k, len, pul);
      tests++;
      if (obs_q[k] !== e) begin
        fails++; $display("FAIL b2b_second k=%0d got=%b required=%b", k, obs_q[k], e);
      end
    end
    tests++;
    if (got_pulses !== 4) begin
      fails++; $display("FAIL b2b_pulses got=%0d required=4", got_pulses);
    end
  endtask

  task automatic test_empty_and_clamp();
    int len, pul;
    int ns [2] = '{0, 40};
    logic [10:0] e;
    foreach (ns[i]) begin
      begin_start(0, ns[i], 1'b0);
      capture(0, ns[i], 0, -1);
      for (int k = 1; k <= cur_len; k++) begin
        e = model(0, ns[i], 0, k, len, pul);
        tests++;
        if (obs_q[k] !== e) begin
          fails++; $display("FAIL len%0d k=%0d got=%b required=%b", ns[i], k, obs_q[k], e);
        end
      end
      tests++;
      if (got_pulses !== pul) begin
        fails++; $display("FAIL len%0d_pulses got=%0d required=%0d", ns[i], got_pulses, pul);
      end
    end
  endtask

  task automatic test_abort();
    int len, pul;
    int aks [3] = '{5, 1, 11};   // third SHIFT pulse, inside LEAD, inside LAG
    logic [10:0] e;
    foreach (aks[i]) begin
      begin_start(0, 8, 1'b0);
      capture(0, 8, aks[i], -1);
      for (int k = 1; k <= cur_len; k++) begin
        e = model(0, 8, aks[i], k, len, pul);
        tests++;
        if (obs_q[k] !== e) begin
          fails++; $display("FAIL abort@%0d k=%0d got=%b required=%b", aks[i], k, obs_q[k], e);
        end
      end
      tests++;
      if (got_pulses !== pul) begin
        fails++; $display("FAIL abort@%0d_pulses got=%0d required=%0d", aks[i], got_pulses, pul);
      end
    end
  endtask

  task automatic test_abort_idle();
    int len, pul;
    logic [10:0] e;
    @(negedge clk_in); abort = 1'b1;
    repeat (3) @(negedge clk_in);
    tests++;
    if (obs_vec(0) !== 11'b1_0_0_0_0_000000) begin
      fails++; $display("FAIL abort_idle got=%b required=%b", obs_vec(0), 11'b10000000000);
    end
    begin_start(0, 3, 1'b1);
    capture(0, 3, 0, -1);
    for (int k = 1; k <= cur_len; k++) begin
      e = model(0, 3, 0, k, len, pul);
      tests++;
      if (obs_q[k] !== e) begin
        fails++; $display("FAIL abort_with_start k=%0d got=%b required=%b", k, obs_q[k], e);
      end
    end
  endtask

  task automatic test_zero_lead_lag();
    int len, pul;
    int ns [3] = '{1, 3, 0};
    logic [10:0] e;
    foreach (ns[i]) begin
      begin_start(1, ns[i], 1'b0);
      capture(1, ns[i], 0, -1);
      for (int k = 1; k <= cur_len; k++) begin
        e = model(1, ns[i], 0, k, len, pul);
        tests++;
        if (obs_q[k] !== e) begin
          fails++; $display("FAIL nolead%0d k=%0d got=%b required=%b", ns[i], k, obs_q[k], e);
        end
      end
      tests++;
      if (got_pulses !== ns[i]) begin
        fails++; $display("FAIL nolead%0d_pulses got=%0d required=%0d", ns[i], got_pulses, ns[i]);
      end
    end
  endtask

  task automatic test_random();
    int len, pul, s, n, abk, span;
    logic [10:0] e;
    for (int it = 0; it < 24; it++) begin
      s = int'($urandom_range(0, 1));
      n = int'($urandom_range(0, 40));
      span = ((s == 0) ? 4 : 0) + ((n > 32) ? 32 : n);
      abk = ($urandom_range(0, 2) == 0 && span > 0) ? int'($urandom_range(1, span)) : 0;
      begin_start(s, n, 1'b0);
      capture(s, n, abk, -1);
      for (int k = 1; k <= cur_len; k++) begin
        e = model(s, n, abk, k, len, pul);
        tests++;
        if (obs_q[k] !== e) begin
          fails++;
          $display("FAIL random it=%0d s=%0d n=%0d abk=%0d k=%0d got=%b required=%b",
                   it, s, n, abk, k, obs_q[k], e);
        end
      end
      tests++;
      if (got_pulses !== pul) begin
        fails++; $display("FAIL random_pulses it=%0d got=%0d required=%0d", it, got_pulses, pul);
      end
    end
  endtask

  task automatic test_async_reset();
    int len, pul;
    logic [10:0] e;
    begin_start(0, 8, 1'b0);
    repeat (4) @(negedge clk_in);
    @(posedge clk_in); #2;
    rst_n = 1'b0; #1;
    tests++;
    if ({obs_vec(0), sr[0], bi0} !== {11'b1_0_0_0_0_000000, 1'b1, 6'd0}) begin
      fails++;
      $display("FAIL async_reset got=%b/%b/%0d required=%b/1/0", obs_vec(0), sr[0], bi0, 11'b10000000000);
    end
    @(negedge clk_in); rst_n = 1'b1;
    @(negedge clk_in);
    tests++;
    if (obs_vec(0) !== 11'b1_0_0_0_0_000000) begin
      fails++; $display("FAIL after_reset got=%b required=%b", obs_vec(0), 11'b10000000000);
    end
    begin_start(0, 2, 1'b0);
    capture(0, 2, 0, -1);
    for (int k = 1; k <= cur_len; k++) begin
      e = model(0, 2, 0, k, len, pul);
      tests++;
      if (obs_q[k] !== e) begin
        fails++; $display("FAIL post_reset_xfer k=%0d got=%b required=%b", k, obs_q[k], e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sv = '0; abort = 1'b0; num_bits = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in); rst_n = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_empty_and_clamp();
    test_abort();
    test_abort_idle();
    test_zero_lead_lag();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
